instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width of the instruction memory.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch word address.
REQ-005 SHALL have: clk  in  1  single clock, all logic rising-edge.
REQ-006 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have: fetch_en  in  1  permits new memory reads.
REQ-008 SHALL have: redirect_valid  in  1  one-cycle pulse, restart fetch at redirect_pc.
REQ-009 SHALL have: redirect_pc  in  ADDR_W  new fetch word address.
REQ-010 SHALL have: mem_address  out  ADDR_W  memory word address.
REQ-011 SHALL have: mem_chipselect  out  1  read issued this cycle.
REQ-012 SHALL have: mem_clken  out  1  constant 1.
REQ-013 SHALL have: mem_write  out  1  constant 0; mem_byteenable  out  4  constant 4'hF; mem_writedata  out  DATA_W  constant 0.
REQ-014 SHALL have: mem_readdata  in  DATA_W  memory data, valid one cycle after issue.
REQ-015 SHALL have: instr_valid  out  1; instr_data  out  DATA_W; instr_pc  out  ADDR_W; instr_ready  in  1 -- decode-side valid/ready handshake.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, FLUSH.
REQ-017 SHALL go IDLE->FETCH on the first cycle after reset deasserts.
REQ-018 SHALL, in FETCH, assert mem_chipselect with mem_address=pc when fetch_en=1 and (FIFO occupancy + outstanding reads) < FIFO_DEPTH, then increment pc by 1.
REQ-019 SHALL wrap pc from 2^ADDR_W-1 to 0.
REQ-020 SHALL treat read latency as exactly 1 cycle: mem_readdata sampled the cycle after issue and written into the FIFO with its pc at that clock edge.
REQ-021 SHALL drive instr_valid/instr_data/instr_pc from the FIFO head (registered, no bypass); a transfer occurs when instr_valid & instr_ready; instr_data/instr_pc SHALL hold while instr_valid & ~instr_ready.
REQ-022 SHALL allow simultaneous FIFO push and pop when full or empty without loss or duplication.
REQ-023 SHALL, on redirect_valid in any state except IDLE, clear the FIFO at that edge, load pc<=redirect_pc, and enter FLUSH.
REQ-024 SHALL, in FLUSH, discard any read response returning that cycle, issue a read of pc if fetch_en=1, and return to FETCH.
REQ-025 SHALL give redirect priority over a same-cycle pop; the popped entry counts as consumed and instr_valid SHALL be 0 the next cycle.
REQ-026 SHALL ignore redirect_valid in IDLE.
REQ-027 SHALL, with fetch_en=0, issue nothing while still accepting the in-flight response and draining the FIFO.

Reset
REQ-028 SHALL on reset: state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, instr_valid=0, instr_data=0, instr_pc=0, mem_chipselect=0, mem_address=0.
REQ-029 SHALL, if reset asserts mid-operation, drop in-flight responses and all FIFO contents.

Configuration
REQ-030 SHALL, with macro IFU_PERF_CNT_EN defined, add outputs perf_fetch_cnt (32b, increments per instr transfer) and perf_redirect_cnt (16b, increments per accepted redirect), both saturating, reset to 0.
REQ-031 SHALL, without IFU_PERF_CNT_EN, omit those ports and counters with otherwise identical behaviour.

Structure
REQ-032 SHALL place FSM state enum and the constant memory-side values (byteenable 4'hF, write 0) in shared package ifu_pkg.
REQ-033 SHALL implement the buffer as sub-module ifu_fifo (synchronous, DATA_W+ADDR_W wide, FIFO_DEPTH deep, full/empty/count outputs).

Verification
REQ-034 Reset release, fetch_en=1, instr_ready=1 -> mem_chipselect at cycle 1 with addr 0; instr_valid at cycle 3 with instr_pc=0, then pc 1,2,3 on consecutive cycles.
REQ-035 instr_ready=0 for 10 cycles -> exactly 4 reads issued, FIFO full, no further chipselect; instr_ready=1 -> pcs 0..3 delivered in order, fetch resumes at 4.
REQ-036 Redirect to 0x80 while FIFO holds pcs 5..7 and a read is in flight -> no 5..8 delivered; next delivered instr_pc=0x80, 0x81.
REQ-037 redirect_pc=0xFE, free-running -> delivered pcs 0xFE, 0xFF, 0x00, 0x01.
REQ-038 Redirect coincident with a pop, and reset asserted mid-stream -> instr_valid=0 the next cycle; after reset fetch restarts at RESET_PC.
REQ-039 With IFU_PERF_CNT_EN: 20 transfers and 3 redirects -> perf_fetch_cnt=20, perf_redirect_cnt=3.

Source files
------------

// File: rtl/ifu_pkg.sv
// ---------------------------------------------------------------------------
// ifu_pkg -- shared definitions for the instruction fetch unit.
//
// Contents:
//   ifu_state_e     : fetch controller states (IDLE, FETCH, FLUSH)
//   MEM_BYTEENABLE  : byte enables driven on the read-only memory port
//   MEM_WRITE       : write strobe value (the fetch port never writes)
//   MEM_CLKEN       : memory clock enable value (always enabled)
// ---------------------------------------------------------------------------
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  localparam logic [3:0] MEM_BYTEENABLE = 4'hF;
  localparam logic       MEM_WRITE      = 1'b0;
  localparam logic       MEM_CLKEN      = 1'b1;

endpackage

// File: rtl/ifu_fifo.sv
// ---------------------------------------------------------------------------
// ifu_fifo -- synchronous instruction buffer with a registered head.
//
// Parameters:
//   WIDTH : entry width (instruction data concatenated with its pc)
//   DEPTH : number of entries, power of two, >= 2
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset, empties and zeroes storage
//   clear      in   synchronous flush, wins over push and pop
//   push       in   write push_data this edge (accepted if not full or popping)
//   push_data  in   WIDTH entry to write
//   pop        in   consume the head entry this edge (ignored when empty)
//   head_data  out  WIDTH current head entry, straight from storage flops
//   full       out  all DEPTH entries occupied
//   empty      out  no entries occupied
//   count      out  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module ifu_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop is only meaningful when something is stored. A push into a full
  // buffer is still taken when the head leaves on the same edge, so a
  // full buffer can stream without losing or duplicating an entry.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = storage[rd_ptr];

  // Pointer, occupancy and storage update. Storage is zeroed on reset so
  // the head reads as zero until the first entry arrives; a clear only
  // rewinds the pointers because stale data is masked by empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit -- sequential instruction fetcher feeding a decode stage.
//
// Reads consecutive word addresses from a one-cycle-latency instruction
// memory, buffers the returned words with their pc in ifu_fifo, and hands
// them to decode over a valid/ready handshake. A redirect pulse flushes
// the buffer and any reads still in flight, then restarts at the new pc.
//
// Parameters:
//   ADDR_W     : word-address width of the instruction memory
//   DATA_W     : instruction width
//   FIFO_DEPTH : instruction buffer entries (power of two, >= 2)
//   RESET_PC   : first fetch word address after reset
//
// Ports:
//   clk                in   rising-edge clock
//   reset              in   synchronous active-high reset
//   fetch_en           in   permits new memory reads
//   redirect_valid     in   one-cycle pulse, restart fetch at redirect_pc
//   redirect_pc        in   ADDR_W new fetch word address
//   mem_address        out  ADDR_W memory word address (registered)
//   mem_chipselect     out  read issued this cycle (registered)
//   mem_clken          out  constant 1
//   mem_write          out  constant 0
//   mem_byteenable     out  constant 4'hF
//   mem_writedata      out  DATA_W constant 0
//   mem_readdata       in   DATA_W memory data, valid the cycle after issue
//   instr_valid        out  buffer head is valid
//   instr_data         out  DATA_W head instruction
//   instr_pc           out  ADDR_W head instruction's word address
//   instr_ready        in   decode accepts the head this cycle
//
// Optional build macro IFU_PERF_CNT_EN adds saturating counters:
//   perf_fetch_cnt     out  32 instructions handed to decode
//   perf_redirect_cnt  out  16 redirects accepted
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [15:0]       perf_redirect_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = DATA_W + ADDR_W;

  ifu_state_e        state;
  logic [ADDR_W-1:0] pc;
  logic              rsp_pend;
  logic [ADDR_W-1:0] rsp_pc;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [EW-1:0]     fifo_head;
  logic              pop;
  logic              redirect_accept;
  logic [CW-1:0]     used;
  logic              issue_ok;

  assign mem_clken      = MEM_CLKEN;
  assign mem_write      = MEM_WRITE;
  assign mem_byteenable = MEM_BYTEENABLE;
  assign mem_writedata  = '0;

  // Redirects are only honoured once the controller has left IDLE.
  assign redirect_accept = redirect_valid && (state != IDLE);
  assign pop             = instr_valid && instr_ready;

  // Every read on the bus (chipselect) or returning (rsp_pend) already
  // owns a buffer slot, so a new read is allowed only while the buffer
  // plus those reservations leaves a slot free. This never lets a
  // response arrive at a full buffer.
  assign used     = fifo_count + CW'(mem_chipselect) + CW'(rsp_pend);
  assign issue_ok = fetch_en && !fifo_full && (used < CW'(FIFO_DEPTH));

  // Fetch controller. chipselect/address are registered, so a read decided
  // at an edge is on the bus for the following cycle; rsp_pend/rsp_pc
  // follow one cycle behind and mark the cycle mem_readdata is valid. A
  // redirect kills the returning response by clearing rsp_pend, and the
  // read issued just before the redirect lands in FLUSH with rsp_pend
  // low, so both in-flight reads are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= ADDR_W'(RESET_PC);
      mem_chipselect <= 1'b0;
      mem_address    <= '0;
      rsp_pend       <= 1'b0;
      rsp_pc         <= '0;
    end else begin
      rsp_pend       <= mem_chipselect;
      rsp_pc         <= mem_address;
      mem_chipselect <= 1'b0;
      case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH, FLUSH: begin
          if (redirect_accept) begin
            pc       <= redirect_pc;
            rsp_pend <= 1'b0;
            state    <= FLUSH;
          end else begin
            state <= FETCH;
            if (issue_ok) begin
              mem_chipselect <= 1'b1;
              mem_address    <= pc;
              pc             <= pc + ADDR_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Instruction buffer. The head comes straight from its storage flops,
  // and a redirect clears it with priority over a same-cycle pop.
  ifu_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_accept),
    .push      (rsp_pend),
    .push_data ({mem_readdata, rsp_pc}),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_head[EW-1:ADDR_W];
  assign instr_pc    = fifo_head[ADDR_W-1:0];

`ifdef IFU_PERF_CNT_EN
  // Saturating activity counters. An entry popped on the same edge as a
  // redirect still counts as delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt    <= '0;
      perf_redirect_cnt <= '0;
    end else begin
      if (pop && (perf_fetch_cnt != '1)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (redirect_accept && (perf_redirect_cnt != '1)) begin
        perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit -- scoreboard bench for instr_fetch_unit.
//
// The main thread drives directed scenarios one cycle at a time (inputs
// change 1 time unit after the rising edge) and queues the pcs it expects
// decode to receive. A monitor on the falling edge pops the queue on every
// valid/ready transfer and compares pc and data against a local memory
// image. Build with IFU_PERF_CNT_EN defined to also check the counters.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  mem_address;
  logic        mem_chipselect;
  logic        mem_clken;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        instr_ready;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [15:0] perf_redirect_cnt;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_pc;
  int          issue_cnt;

  instr_fetch_unit u_dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_clken      (mem_clken),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: every word encodes its own address so a wrong or stale
  // instruction shows up as a data miscompare as well as a pc miscompare.
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hC3, a, ~a, a ^ 8'h5A};
  endfunction

  // One-cycle-latency synchronous instruction memory.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_readdata <= mem_word(mem_address);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [7:0] rpc);
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic pushRange(input logic [7:0] lo, input int n);
    logic [7:0] p;
    p = lo;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + 8'd1;
    end
  endtask

  // Runs until the read of 'stop' is seen on the bus, then drops fetch_en
  // so that read is the last one issued.
  task automatic runUntilIssued(input logic [7:0] stop);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (mem_chipselect && mem_address == stop) begin
        found    = 1'b1;
        fetch_en = 1'b0;
      end
    end
    checkOutput("issue_reached", 32'(found), 32'd1);
  endtask

  task automatic drain();
    repeat (8) cyc();
    checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_valid", 32'(instr_valid), 32'd0);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected pc.
  always @(negedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_transfer: got pc 0x%0h, expected none", instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        checkOutput("xfer_pc", 32'(instr_pc), 32'(exp_pc));
        checkOutput("xfer_data", instr_data, mem_word(exp_pc));
      end
    end
  end

  // Safety net against a hung handshake.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  // Directed scenarios.
  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) cyc();

    // Reset values and constant memory-side outputs.
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_data", instr_data, 32'd0);
    checkOutput("rst_pc", 32'(instr_pc), 32'd0);
    checkOutput("rst_cs", 32'(mem_chipselect), 32'd0);
    checkOutput("rst_addr", 32'(mem_address), 32'd0);
    checkOutput("const_clken", 32'(mem_clken), 32'd1);
    checkOutput("const_write", 32'(mem_write), 32'd0);
    checkOutput("const_byteen", 32'(mem_byteenable), 32'hF);
    checkOutput("const_wdata", mem_writedata, 32'd0);

    // Startup latency: read of 0 on the bus at cycle 1, first instruction
    // at cycle 3, then one per cycle. Five reads (0..4) before fetch stops.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    pushRange(8'h00, 5);
    cyc();
    checkOutput("start_c0_cs", 32'(mem_chipselect), 32'd0);
    cyc();
    checkOutput("start_c1_cs", 32'(mem_chipselect), 32'd1);
    checkOutput("start_c1_addr", 32'(mem_address), 32'd0);
    cyc();
    checkOutput("start_c2_addr", 32'(mem_address), 32'd1);
    checkOutput("start_c2_valid", 32'(instr_valid), 32'd0);
    cyc();
    checkOutput("start_c3_valid", 32'(instr_valid), 32'd1);
    checkOutput("start_c3_pc", 32'(instr_pc), 32'd0);
    cyc();
    checkOutput("start_c4_pc", 32'(instr_pc), 32'd1);
    cyc();
    checkOutput("start_c5_pc", 32'(instr_pc), 32'd2);
    fetch_en = 1'b0;
    drain();

    // Backpressure: decode stalled for the whole fill, exactly four reads.
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    pushRange(8'h00, 5);
    issue_cnt = 0;
    repeat (11) begin
      cyc();
      if (mem_chipselect) issue_cnt++;
    end
    checkOutput("stall_issue_count", 32'(issue_cnt), 32'd4);
    checkOutput("stall_valid", 32'(instr_valid), 32'd1);
    checkOutput("stall_hold_pc", 32'(instr_pc), 32'd0);
    checkOutput("stall_hold_data", instr_data, mem_word(8'h00));
    checkOutput("stall_cs", 32'(mem_chipselect), 32'd0);
    instr_ready = 1'b1;
    runUntilIssued(8'h04);
    drain();

    // Redirect with 5..7 buffered and the read of 8 still returning.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (5) cyc();
    checkOutput("redir_pre_pc", 32'(instr_pc), 32'h05);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h80);
    cyc();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("redir_valid_cleared", 32'(instr_valid), 32'd0);
    checkOutput("redir_no_issue", 32'(mem_chipselect), 32'd0);
    pushRange(8'h80, 2);
    runUntilIssued(8'h81);
    drain();

    // Address wrap after a redirect near the top of the space.
    pushRange(8'hFE, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE);
    cyc();
    redirect_valid = 1'b0;
    runUntilIssued(8'h01);
    drain();

    // Redirect on the same edge as a pop: the popped pc 2 is delivered,
    // nothing else from the old stream follows.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (5) cyc();
    checkOutput("pop_redir_pre_pc", 32'(instr_pc), 32'h02);
    exp_q.push_back(8'h02);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h40);
    cyc();
    redirect_valid = 1'b0;
    checkOutput("pop_redir_valid", 32'(instr_valid), 32'd0);
    pushRange(8'h40, 2);
    runUntilIssued(8'h41);
    drain();

    // Reset mid-stream, then a redirect pulse while still in IDLE.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (5) cyc();
    checkOutput("midrst_pre_pc", 32'(instr_pc), 32'h42);
    reset = 1'b1;
    cyc();
    checkOutput("midrst_valid", 32'(instr_valid), 32'd0);
    checkOutput("midrst_cs", 32'(mem_chipselect), 32'd0);
    checkOutput("midrst_pc", 32'(instr_pc), 32'd0);
    checkOutput("midrst_data", instr_data, 32'd0);
    cyc();
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h77);
    pushRange(8'h00, 2);
    cyc();
    redirect_valid = 1'b0;
    runUntilIssued(8'h01);
    drain();

    // Three redirects with fetch disabled, then 18 more transfers: since
    // the last reset that makes 20 transfers and 3 accepted redirects.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 8'(i * 16));
      cyc();
      redirect_valid = 1'b0;
      cyc();
    end
    checkOutput("redir_only_valid", 32'(instr_valid), 32'd0);
    fetch_en = 1'b1;
    pushRange(8'h30, 18);
    runUntilIssued(8'h41);
    drain();
`ifdef IFU_PERF_CNT_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'd20);
    checkOutput("perf_redirect_cnt", 32'(perf_redirect_cnt), 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
